// File: rtl/axis_frame_pkg.sv
// Shared types and constants for the AXI-Stream frame transmitter.
package axis_frame_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int STRB_WIDTH_DEF = DATA_WIDTH_DEF / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int strb_width(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/axis_tx_fifo.sv
// First-word-fall-through synchronous FIFO; head word is visible on rd_data_o
// whenever empty_o is low, and rd_en_i pops it.
module axis_tx_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_valid_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          wr_ready_o,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Ready comes from the registered count only, so a full FIFO refuses a push
  // even when a pop happens in the same cycle.
  assign wr_ready_o = (count_q != CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign rd_data_o  = mem_q[rd_ptr_q];

  assign push = wr_valid_i && wr_ready_o;
  assign pop  = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/axis_frame_tx.sv
// AXI-Stream frame transmitter: buffers load words and emits frames of
// frame_len beats. Optional frame counter enabled by AXIS_FRAME_TX_CNT_EN.
module axis_frame_tx
  import axis_frame_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                       m00_axis_aclk,
  input  logic                       m00_axis_aresetn,
  input  logic                       ld_valid,
  input  logic [DATA_WIDTH-1:0]      ld_data,
  output logic                       ld_ready,
  input  logic                       start,
  input  logic [LEN_WIDTH-1:0]       frame_len,
  output logic                       busy,
  output logic                       done,
  output logic                       len_err,
  output logic [DATA_WIDTH-1:0]      m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]    m00_axis_tstrb,
  output logic                       m00_axis_tvalid,
  output logic                       m00_axis_tlast,
  input  logic                       m00_axis_tready
`ifdef AXIS_FRAME_TX_CNT_EN
  , output logic [15:0]              frame_cnt
`endif
);

  localparam int STRB_W = strb_width(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic                  len_err_q, len_err_d;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  tvalid, xfer, last_beat;

  axis_tx_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (m00_axis_aclk),
    .rst_ni     (m00_axis_aresetn),
    .wr_valid_i (ld_valid),
    .wr_data_i  (ld_data),
    .wr_ready_o (ld_ready),
    .rd_en_i    (xfer),
    .rd_data_o  (fifo_data),
    .empty_o    (fifo_empty)
  );

  // Outputs decode registered state and FIFO occupancy, so reset clears them
  // immediately and a stalled beat stays stable until it is taken.
  assign tvalid    = (state_q == ST_SEND) && !fifo_empty;
  assign xfer      = tvalid && m00_axis_tready;
  assign last_beat = (beat_q == len_q - LEN_WIDTH'(1));

  assign m00_axis_tvalid = tvalid;
  assign m00_axis_tdata  = tvalid ? fifo_data : '0;
  assign m00_axis_tstrb  = {STRB_W{tvalid}};
  assign m00_axis_tlast  = tvalid && last_beat;
  assign busy            = (state_q == ST_SEND);
  assign done            = (state_q == ST_DONE);
  assign len_err         = len_err_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    beat_d    = beat_q;
    len_err_d = len_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            len_d   = frame_len;
            beat_d  = '0;
            state_d = ST_SEND;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (xfer) begin
          beat_d = beat_q + LEN_WIDTH'(1);
          if (last_beat) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      beat_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      len_err_q <= len_err_d;
    end
  end

`ifdef AXIS_FRAME_TX_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) frame_cnt_q <= '0;
    else if (state_q == ST_DONE) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_axis_frame_tx.sv
// Directed bench for axis_frame_tx: per-cycle vector table plus hand sequences
// for FIFO full, zero-length start and mid-frame reset.
module tb_axis_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid, start, tready;
  logic [31:0] ld_data;
  logic [7:0]  frame_len;
  logic        ld_ready, busy, done, len_err;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tvalid, tlast;
`ifdef AXIS_FRAME_TX_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_frame_tx dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .ld_valid         (ld_valid),
    .ld_data          (ld_data),
    .ld_ready         (ld_ready),
    .start            (start),
    .frame_len        (frame_len),
    .busy             (busy),
    .done             (done),
    .len_err          (len_err),
    .m00_axis_tdata   (tdata),
    .m00_axis_tstrb   (tstrb),
    .m00_axis_tvalid  (tvalid),
    .m00_axis_tlast   (tlast),
    .m00_axis_tready  (tready)
`ifdef AXIS_FRAME_TX_CNT_EN
    , .frame_cnt      (frame_cnt)
`endif
  );

  typedef struct {
    logic        ldv;
    logic [31:0] ldd;
    logic        st;
    logic [7:0]  len;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic        eb;
    logic        edn;
    logic        elr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ldv, input logic [31:0] ldd, input logic st,
                              input logic [7:0] len, input logic rdy, input logic ev,
                              input logic [31:0] ed, input logic el, input logic eb,
                              input logic edn, input logic elr);
    vec_t v;
    v.ldv = ldv; v.ldd = ldd; v.st = st; v.len = len; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.el = el; v.eb = eb; v.edn = edn; v.elr = elr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ld_valid = 0; ld_data = '0; start = 0; frame_len = '0; tready = 0;

    // Frame of 4, back-to-back beats
    vecs.push_back(mk(1, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 4, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h11, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h22, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h33, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h44, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    // Frame of 4 with a 3-cycle backpressure stall on the second beat
    vecs.push_back(mk(1, 32'hA1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 32'hA2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 32'hA3, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 32'hA4, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'hA1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hA2, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hA2, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hA2, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'hA2, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'hA3, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'hA4, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
    // Frame of 3 with the FIFO running dry after the first beat
    vecs.push_back(mk(1, 32'hB1, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'hB1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 32'hB2, 0, 0, 1, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 32'hB3, 0, 0, 1, 1, 32'hB2, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'hB3, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tstrb", tstrb, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_len_err", len_err, 0);
    check("rst_ld_ready", ld_ready, 1);
    cyc();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      ld_valid = vecs[i].ldv; ld_data = vecs[i].ldd; start = vecs[i].st;
      frame_len = vecs[i].len; tready = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("v%0d_tvalid", i), tvalid, vecs[i].ev);
      check($sformatf("v%0d_tdata", i), tdata, vecs[i].ed);
      check($sformatf("v%0d_tstrb", i), tstrb, vecs[i].ev ? 4'hF : 4'h0);
      check($sformatf("v%0d_tlast", i), tlast, vecs[i].el);
      check($sformatf("v%0d_busy", i), busy, vecs[i].eb);
      check($sformatf("v%0d_done", i), done, vecs[i].edn);
      check($sformatf("v%0d_ld_ready", i), ld_ready, vecs[i].elr);
      check($sformatf("v%0d_len_err", i), len_err, 0);
      cyc();
    end
    ld_valid = 0; start = 0;
`ifdef AXIS_FRAME_TX_CNT_EN
    check("frame_cnt", frame_cnt, 3);
`endif

    // Fill past capacity: 17th word must be refused and dropped
    for (int i = 0; i < 17; i++) begin
      ld_valid = 1; ld_data = 32'h100 + i;
      @(negedge clk);
      check($sformatf("fill%0d_ld_ready", i), ld_ready, (i < 16) ? 1 : 0);
      cyc();
    end
    ld_valid = 0; start = 1; frame_len = 8'd16; tready = 1;
    cyc();
    start = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("full_b%0d_tvalid", i), tvalid, 1);
      check($sformatf("full_b%0d_tdata", i), tdata, 32'h100 + i);
      check($sformatf("full_b%0d_tlast", i), tlast, (i == 15) ? 1 : 0);
      cyc();
    end
    @(negedge clk);
    check("full_done", done, 1);
    cyc();
    start = 1; frame_len = 8'd1;
    cyc();
    start = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("full_empty_tvalid", tvalid, 0);
      check("full_empty_busy", busy, 1);
      cyc();
    end
    rst_n = 0;
    cyc();
    rst_n = 1;

    // Zero-length start sets the sticky error and stays idle
    start = 1; frame_len = 8'd0;
    cyc();
    start = 0;
    @(negedge clk);
    check("len0_len_err", len_err, 1);
    check("len0_tvalid", tvalid, 0);
    check("len0_busy", busy, 0);
    cyc();

    // Reset in the middle of a frame of 8
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1; ld_data = 32'h200 + i;
      cyc();
    end
    ld_valid = 0; start = 1; frame_len = 8'd8; tready = 1;
    cyc();
    start = 0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      check($sformatf("mid_b%0d_tdata", b), tdata, 32'h200 + b);
      cyc();
    end
    @(negedge clk);
    check("mid_b2_tdata", tdata, 32'h202);
    #1 rst_n = 0;
    #1;
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_tlast", tlast, 0);
    check("mid_rst_tdata", tdata, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_len_err", len_err, 0);
    check("mid_rst_ld_ready", ld_ready, 1);
    cyc();
    rst_n = 1;
    start = 1; frame_len = 8'd1;
    cyc();
    start = 0;
    @(negedge clk);
    check("post_rst_empty_tvalid", tvalid, 0);
    check("post_rst_busy", busy, 1);
    cyc();
    ld_valid = 1; ld_data = 32'h5A;
    cyc();
    ld_valid = 0;
    @(negedge clk);
    check("post_rst_tvalid", tvalid, 1);
    check("post_rst_tdata", tdata, 32'h5A);
    check("post_rst_tlast", tlast, 1);
    cyc();
    @(negedge clk);
    check("post_rst_done", done, 1);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_frame_tx.md
AXIS_FRAME_TX -- requirements
Module: axis_frame_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the stream data width in bits (a multiple of 8).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, giving the number of buffered words (a power of 2).
REQ-003 The block SHALL have parameter LEN_WIDTH, default 8, giving the width of the frame-length field.
REQ-004 Port m00_axis_aclk SHALL be an input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port m00_axis_aresetn SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-006 Port ld_valid SHALL be an input, 1 bit: load word valid.
REQ-007 Port ld_data SHALL be an input, DATA_WIDTH bits: load word.
REQ-008 Port ld_ready SHALL be an output, 1 bit: the FIFO can accept a word.
REQ-009 Port start SHALL be an input, 1 bit: frame request.
REQ-010 Port frame_len SHALL be an input, LEN_WIDTH bits: beats per frame, sampled when start is accepted.
REQ-011 Ports busy, done and len_err SHALL each be a 1-bit output: frame in progress; one-cycle completion pulse; sticky zero-length error.
REQ-012 Ports m00_axis_tdata (output, DATA_WIDTH bits), m00_axis_tstrb (output, DATA_WIDTH/8 bits), m00_axis_tvalid (output, 1 bit) and m00_axis_tlast (output, 1 bit) SHALL form the AXI-Stream master port.
REQ-013 Port m00_axis_tready SHALL be an input, 1 bit: downstream ready.

Function
REQ-014 A word SHALL be pushed on a cycle with ld_valid && ld_ready; ld_ready SHALL be 0 when the FIFO is full, and a word offered then SHALL be dropped.
REQ-015 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count SHALL be clog2(FIFO_DEPTH)+1 bits wide.
REQ-016 The FSM states SHALL be IDLE, SEND and DONE.
REQ-017 In IDLE, start with frame_len != 0 SHALL latch frame_len, clear the beat counter, set busy=1 and move to SEND.
REQ-018 In IDLE, start with frame_len == 0 SHALL set len_err=1 and stay in IDLE.
REQ-019 start SHALL be ignored in SEND and DONE.
REQ-020 In SEND, m00_axis_tvalid SHALL be 1 exactly when a word is available from the FIFO.
REQ-021 A beat SHALL transfer on tvalid && tready; each transfer pops one word and increments the beat counter.
REQ-022 m00_axis_tlast SHALL be 1 only on the beat whose index equals latched length - 1.
REQ-023 While tvalid && !tready, tdata, tstrb and tlast SHALL stay stable, and tvalid SHALL NOT be withdrawn.
REQ-024 m00_axis_tstrb SHALL be all-ones on valid beats and 0 otherwise; tdata SHALL be 0 (never Z) when tvalid is 0.
REQ-025 Latency: with a non-empty FIFO, tvalid SHALL rise the cycle after start is accepted.
REQ-026 Throughput: with tready held at 1 and the FIFO non-empty, the block SHALL transfer one beat per cycle.
REQ-027 An empty FIFO mid-frame SHALL drop tvalid until data arrives, then resume the frame without error.
REQ-028 The last transfer SHALL move the FSM to DONE; DONE SHALL assert done=1 for one cycle, clear busy and return to IDLE.
REQ-029 A simultaneous push and pop SHALL leave occupancy unchanged.
REQ-030 ld_ready SHALL be derived from the registered count, so a push is refused when the FIFO is full even if a pop occurs in the same cycle.

Reset
REQ-031 Asserting m00_axis_aresetn low SHALL immediately (asynchronously) clear tvalid, tlast, tstrb, tdata, busy, done and len_err, empty the FIFO and force IDLE.
REQ-032 Reset mid-frame SHALL abandon the frame with no tlast emitted; normal operation SHALL resume on the first clock edge after deassertion.

Configuration
REQ-033 With macro AXIS_FRAME_TX_CNT_EN defined, the block SHALL add output frame_cnt, 16 bits, reset to 0, incremented on each done pulse and wrapping from 0xFFFF to 0.
REQ-034 Without AXIS_FRAME_TX_CNT_EN, the port and its counter SHALL be absent.

Structure
REQ-035 Shared package axis_frame_pkg SHALL hold the FSM state enum, the default DATA_WIDTH and the strobe-width constant DATA_WIDTH/8.
REQ-036 The FIFO SHALL be sub-module axis_tx_fifo: synchronous, first-word-fall-through, with async active-low reset.

Verification
REQ-037 Load 0x11, 0x22, 0x33, 0x44; start len=4 with tready=1 -> four consecutive beats in order, tlast only on 0x44, done pulse the next cycle, busy=0 after.
REQ-038 Frame of 4 with tready=0 during beats 2-3 for 3 cycles -> tdata and tlast held stable, no beat lost or duplicated.
REQ-039 Load 1 word, start len=3, load 2 more words 5 cycles later -> tvalid gap, then resume, tlast on the third word, len_err=0.
REQ-040 Push 17 words -> ld_ready=0 after 16, 17th word dropped; start len=16 -> 16 words out in order, FIFO empty.
REQ-041 start with len=0 -> len_err=1, tvalid stays 0; assert reset at beat 2 of a len=8 frame -> tvalid=0 at once, len_err=0, FIFO empty.
REQ-042 With AXIS_FRAME_TX_CNT_EN defined, send 3 frames -> frame_cnt=3.
